hazard_sched: RTL and testbench

- Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards and sequences multi-cycle data-memory waits with a bounded timeout.
- Drives hold, bubble and flush controls into the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Purely a controller: no datapath values pass through it.

---
 rtl/hazard_sched.sv | 190 +++++++++++++++++++
 tb/tb_hazard_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// ---------------------------------------------------------------------------
// hazard_sched
//
// Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// It detects load-use hazards, sequences multi-cycle data-memory waits with a
// bounded timeout, and drives hold/bubble/flush controls into the pipeline
// registers and the PC. No datapath values pass through this block.
//
// Parameters
//   MEM_TIMEOUT : max consecutive MEM_WAIT cycles tolerated (1..255)
//   CNT_W       : wait counter width, 2**CNT_W > MEM_TIMEOUT
//
// Ports
//   clk_i, rst_i (synchronous, active low)
//   id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_branch_taken_i : ID stage
//   ex_ctrl_i, ex_rd_i   : EX-stage control code and destination register
//   mem_ctrl_i           : MEM-stage control code
//   dmem_ready_i         : data memory completes the access this cycle
//   dmem_req_o           : data memory request
//   pc_write_o           : PC update enable
//   ifid_hold_o / ifid_flush_o, idex_hold_o / idex_bubble_o,
//   exmem_hold_o, memwb_bubble_o : pipeline register controls
//   mem_timeout_o        : sticky fatal-timeout flag
//   state_o              : FSM state (RUN=0, LU_STALL=1, MEM_WAIT=2, ERROR=3)
//
// Optional build macro HAZ_SCHED_PERF_EN adds two saturating 32-bit counters:
//   stall_cnt_o : cycles with pc_write_o=0 outside ERROR
//   flush_cnt_o : cycles with ifid_flush_o=1
//
// Handshake: dmem_req_o is a request held for as long as the MEM-stage access
// is pending; the access completes in the cycle where dmem_req_o=1 and
// dmem_ready_i=1. dmem_ready_i is ignored in every other cycle.
// ---------------------------------------------------------------------------

// Pipeline control-code encoding shared with the datapath.
`ifndef Ctrl_NOP
`define Ctrl_NOP 4'h0
`endif
`ifndef Ctrl_LW
`define Ctrl_LW 4'h1
`endif
`ifndef Ctrl_SW
`define Ctrl_SW 4'h2
`endif

module hazard_sched #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic        id_branch_taken_i,
    input  logic [3:0]  ex_ctrl_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [3:0]  mem_ctrl_i,
    input  logic        dmem_ready_i,
    output logic        dmem_req_o,
    output logic        pc_write_o,
    output logic        ifid_hold_o,
    output logic        ifid_flush_o,
    output logic        idex_hold_o,
    output logic        idex_bubble_o,
    output logic        exmem_hold_o,
    output logic        memwb_bubble_o,
    output logic        mem_timeout_o,
`ifdef HAZ_SCHED_PERF_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
`endif
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    // Counter value seen on the last tolerated stalled cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    logic mem_acc;
    logic mem_stall;
    logic load_use;
    logic in_error;

    assign in_error  = (state_q == ST_ERROR);
    assign mem_acc   = (mem_ctrl_i == `Ctrl_LW) || (mem_ctrl_i == `Ctrl_SW);
    assign mem_stall = mem_acc && !dmem_ready_i && !in_error;
    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use  = (ex_ctrl_i == `Ctrl_LW) && (ex_rd_i != 5'd0) &&
                       ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                        (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state and control outputs, priority ERROR > mem_stall > load_use > branch.
    always_comb begin
        state_d        = ST_RUN;
        wait_cnt_d     = '0;
        timeout_d      = timeout_q;
        pc_write_o     = 1'b1;
        ifid_hold_o    = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_hold_o    = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_hold_o   = 1'b0;
        memwb_bubble_o = 1'b0;

        if (in_error) begin
            // Freeze the whole pipeline until reset.
            state_d        = ST_ERROR;
            pc_write_o     = 1'b0;
            ifid_hold_o    = 1'b1;
            idex_hold_o    = 1'b1;
            exmem_hold_o   = 1'b1;
            memwb_bubble_o = 1'b1;
        end else if (mem_stall) begin
            // Flush and load-use bubbles are suppressed here: the held ID
            // instruction is re-evaluated once the memory access completes.
            pc_write_o     = 1'b0;
            ifid_hold_o    = 1'b1;
            idex_hold_o    = 1'b1;
            exmem_hold_o   = 1'b1;
            memwb_bubble_o = 1'b1;
            wait_cnt_d     = wait_cnt_q + 1'b1;
            if (wait_cnt_q == LAST_CNT) begin
                state_d   = ST_ERROR;
                timeout_d = 1'b1;
            end else begin
                state_d   = ST_MEM_WAIT;
            end
        end else if (load_use) begin
            // Branch flush is deferred: the ID instruction stays put one cycle.
            pc_write_o    = 1'b0;
            ifid_hold_o   = 1'b1;
            idex_bubble_o = 1'b1;
            state_d       = ST_LU_STALL;
        end else begin
            ifid_flush_o  = id_branch_taken_i;
        end
    end

    assign dmem_req_o    = mem_acc && !in_error;
    assign mem_timeout_o = timeout_q;
    assign state_o       = state_q;

`ifdef HAZ_SCHED_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write_o && !in_error && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ifid_flush_o && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// ---------------------------------------------------------------------------
// tb_hazard_sched
//
// Self-checking bench for hazard_sched (MEM_TIMEOUT=4). Directed scenario
// tasks plus a randomized run checked against a cycle-level reference model
// built from the scheduling rules (consecutive-stall count, sticky error).
// Observed outputs are packed as:
//   [10] dmem_req [9] pc_write [8] ifid_hold [7] ifid_flush [6] idex_hold
//   [5] idex_bubble [4] exmem_hold [3] memwb_bubble [2] mem_timeout [1:0] state
// ---------------------------------------------------------------------------
`ifndef Ctrl_NOP
`define Ctrl_NOP 4'h0
`endif
`ifndef Ctrl_LW
`define Ctrl_LW 4'h1
`endif
`ifndef Ctrl_SW
`define Ctrl_SW 4'h2
`endif

module tb_hazard_sched;

    localparam int TIMEOUT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  id_rs1_i, id_rs2_i;
    logic        id_use_rs1_i, id_use_rs2_i, id_branch_taken_i;
    logic [3:0]  ex_ctrl_i;
    logic [4:0]  ex_rd_i;
    logic [3:0]  mem_ctrl_i;
    logic        dmem_ready_i;
    logic        dmem_req_o, pc_write_o, ifid_hold_o, ifid_flush_o;
    logic        idex_hold_o, idex_bubble_o, exmem_hold_o, memwb_bubble_o;
    logic        mem_timeout_o;
    logic [1:0]  state_o;
`ifdef HAZ_SCHED_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    logic [10:0] outs;
    logic [10:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    assign outs = {dmem_req_o, pc_write_o, ifid_hold_o, ifid_flush_o, idex_hold_o,
                   idex_bubble_o, exmem_hold_o, memwb_bubble_o, mem_timeout_o, state_o};

    hazard_sched #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .id_use_rs1_i      (id_use_rs1_i),
        .id_use_rs2_i      (id_use_rs2_i),
        .id_branch_taken_i (id_branch_taken_i),
        .ex_ctrl_i         (ex_ctrl_i),
        .ex_rd_i           (ex_rd_i),
        .mem_ctrl_i        (mem_ctrl_i),
        .dmem_ready_i      (dmem_ready_i),
        .dmem_req_o        (dmem_req_o),
        .pc_write_o        (pc_write_o),
        .ifid_hold_o       (ifid_hold_o),
        .ifid_flush_o      (ifid_flush_o),
        .idex_hold_o       (idex_hold_o),
        .idex_bubble_o     (idex_bubble_o),
        .exmem_hold_o      (exmem_hold_o),
        .memwb_bubble_o    (memwb_bubble_o),
        .mem_timeout_o     (mem_timeout_o),
`ifdef HAZ_SCHED_PERF_EN
        .stall_cnt_o       (stall_cnt_o),
        .flush_cnt_o       (flush_cnt_o),
`endif
        .state_o           (state_o)
    );

    // Clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change at the falling edge, checks land #1 later.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic set_idle();
        id_rs1_i          = 5'd0;
        id_rs2_i          = 5'd0;
        id_use_rs1_i      = 1'b0;
        id_use_rs2_i      = 1'b0;
        id_branch_taken_i = 1'b0;
        ex_ctrl_i         = `Ctrl_NOP;
        ex_rd_i           = 5'd0;
        mem_ctrl_i        = `Ctrl_NOP;
        dmem_ready_i      = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        set_idle();
        step();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (outs !== 11'b0_1_0_0_0_0_0_0_0_00) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", outs, 11'b0_1_0_0_0_0_0_0_0_00);
        end
    endtask

    task automatic test_load_use();
        ex_ctrl_i = `Ctrl_LW; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_use_rs1_i = 1'b1;
        #1;
        checks++;
        if (outs !== 11'b0_0_1_0_0_1_0_0_0_00) begin
            errors++;
            $display("FAIL load_use_stall: got %b expected %b", outs, 11'b0_0_1_0_0_1_0_0_0_00);
        end
        step();
        ex_ctrl_i = `Ctrl_NOP;
        #1;
        checks++;
        if (outs !== 11'b0_1_0_0_0_0_0_0_0_01) begin
            errors++;
            $display("FAIL load_use_state: got %b expected %b", outs, 11'b0_1_0_0_0_0_0_0_0_01);
        end
        step();
        #1;
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL load_use_return: got %0d expected 0", state_o);
        end
        set_idle();
    endtask

    task automatic test_zero_rd();
        ex_ctrl_i = `Ctrl_LW; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_use_rs1_i = 1'b1;
        id_rs2_i = 5'd0; id_use_rs2_i = 1'b1;
        #1;
        checks++;
        if (outs !== 11'b0_1_0_0_0_0_0_0_0_00) begin
            errors++;
            $display("FAIL zero_rd: got %b expected %b", outs, 11'b0_1_0_0_0_0_0_0_0_00);
        end
        step();
        #1;
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL zero_rd_state: got %0d expected 0", state_o);
        end
        set_idle();
    endtask

    // Two back-to-back 3-cycle waits: with TIMEOUT=4 the second only
    // survives if the counter cleared after the first completed.
    task automatic test_mem_wait();
        logic [10:0] e;
        for (int rep = 0; rep < 2; rep++) begin
            mem_ctrl_i = `Ctrl_LW;
            for (int i = 0; i < 3; i++) begin
                dmem_ready_i = 1'b0;
                #1;
                e = {9'b1_0_1_0_1_0_1_1_0, (i == 0) ? 2'd0 : 2'd2};
                checks++;
                if (outs !== e) begin
                    errors++;
                    $display("FAIL mem_wait_stall rep%0d cyc%0d: got %b expected %b", rep, i, outs, e);
                end
                step();
            end
            dmem_ready_i = 1'b1;
            #1;
            checks++;
            if (outs !== 11'b1_1_0_0_0_0_0_0_0_10) begin
                errors++;
                $display("FAIL mem_wait_done rep%0d: got %b expected %b", rep, outs, 11'b1_1_0_0_0_0_0_0_0_10);
            end
            step();
        end
        set_idle();
        #1;
        checks++;
        if (outs !== 11'b0_1_0_0_0_0_0_0_0_00) begin
            errors++;
            $display("FAIL mem_wait_after: got %b expected %b", outs, 11'b0_1_0_0_0_0_0_0_0_00);
        end
        step();
    endtask

    task automatic test_ready_last_cycle();
        mem_ctrl_i = `Ctrl_LW;
        dmem_ready_i = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        dmem_ready_i = 1'b1;
        #1;
        checks++;
        if (outs !== 11'b1_1_0_0_0_0_0_0_0_10) begin
            errors++;
            $display("FAIL ready_last: got %b expected %b", outs, 11'b1_1_0_0_0_0_0_0_0_10);
        end
        step();
        set_idle();
        #1;
        checks++;
        if (outs !== 11'b0_1_0_0_0_0_0_0_0_00) begin
            errors++;
            $display("FAIL ready_last_after: got %b expected %b", outs, 11'b0_1_0_0_0_0_0_0_0_00);
        end
        step();
    endtask

    task automatic test_timeout();
        mem_ctrl_i = `Ctrl_SW;
        dmem_ready_i = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) step();
        #1;
        checks++;
        if (outs !== 11'b0_0_1_0_1_0_1_1_1_11) begin
            errors++;
            $display("FAIL timeout_error: got %b expected %b", outs, 11'b0_0_1_0_1_0_1_1_1_11);
        end
        // ERROR is sticky even once memory answers and hazards vanish.
        dmem_ready_i = 1'b1;
        id_branch_taken_i = 1'b1;
        step();
        #1;
        checks++;
        if (outs !== 11'b0_0_1_0_1_0_1_1_1_11) begin
            errors++;
            $display("FAIL timeout_sticky: got %b expected %b", outs, 11'b0_0_1_0_1_0_1_1_1_11);
        end
        do_reset();
        #1;
        checks++;
        if (outs !== 11'b0_1_0_0_0_0_0_0_0_00) begin
            errors++;
            $display("FAIL timeout_reset: got %b expected %b", outs, 11'b0_1_0_0_0_0_0_0_0_00);
        end
    endtask

    task automatic test_branch_during_stall();
        logic [10:0] e;
        mem_ctrl_i = `Ctrl_LW;
        dmem_ready_i = 1'b0;
        id_branch_taken_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            e = {9'b1_0_1_0_1_0_1_1_0, (i == 0) ? 2'd0 : 2'd2};
            checks++;
            if (outs !== e) begin
                errors++;
                $display("FAIL branch_stall cyc%0d: got %b expected %b", i, outs, e);
            end
            step();
        end
        dmem_ready_i = 1'b1;
        #1;
        checks++;
        if (outs !== 11'b1_1_0_1_0_0_0_0_0_10) begin
            errors++;
            $display("FAIL branch_flush_after: got %b expected %b", outs, 11'b1_1_0_1_0_0_0_0_0_10);
        end
        step();
        set_idle();
        step();
    endtask

    // Randomized run against a rule-level model: a count of consecutive
    // stalled cycles, a sticky error flag and the expected visible state.
    task automatic test_random();
        int          m_cnt;
        logic        m_err;
        logic [1:0]  m_st;
        logic        acc, stall, lu;
        logic [10:0] e, got_e;
        do_reset();
        m_cnt = 0; m_err = 1'b0; m_st = 2'd0;
        for (int n = 0; n < 1500; n++) begin
            rst_i             = ($urandom_range(0, 63) != 0);
            id_rs1_i          = 5'($urandom_range(0, 3));
            id_rs2_i          = 5'($urandom_range(0, 3));
            id_use_rs1_i      = 1'($urandom_range(0, 1));
            id_use_rs2_i      = 1'($urandom_range(0, 1));
            id_branch_taken_i = 1'($urandom_range(0, 1));
            ex_ctrl_i         = 4'($urandom_range(0, 3));
            ex_rd_i           = 5'($urandom_range(0, 3));
            mem_ctrl_i        = 4'($urandom_range(0, 3));
            dmem_ready_i      = ($urandom_range(0, 3) == 0);

            acc   = (mem_ctrl_i == `Ctrl_LW) || (mem_ctrl_i == `Ctrl_SW);
            stall = acc && !dmem_ready_i && !m_err;
            lu    = (ex_ctrl_i == `Ctrl_LW) && (ex_rd_i != 5'd0) &&
                    ((id_use_rs1_i && id_rs1_i == ex_rd_i) || (id_use_rs2_i && id_rs2_i == ex_rd_i));
            if (m_err)      e = 11'b0_0_1_0_1_0_1_1_1_11;
            else if (stall) e = {9'b1_0_1_0_1_0_1_1_0, m_st};
            else if (lu)    e = {acc, 8'b0_1_0_0_1_0_0_0, m_st};
            else            e = {acc, 1'b1, 1'b0, id_branch_taken_i, 5'b0_0_0_0_0, m_st};
            exp_q.push_back(e);

            #1;
            got_e = exp_q.pop_front();
            checks++;
            if (outs !== got_e) begin
                errors++;
                $display("FAIL random cyc%0d: got %b expected %b", n, outs, got_e);
            end

            if (!rst_i) begin
                m_err = 1'b0; m_cnt = 0; m_st = 2'd0;
            end else if (!m_err) begin
                if (stall) begin
                    m_cnt++;
                    if (m_cnt == TIMEOUT) begin
                        m_err = 1'b1; m_st = 2'd3;
                    end else begin
                        m_st = 2'd2;
                    end
                end else begin
                    m_cnt = 0;
                    m_st = lu ? 2'd1 : 2'd0;
                end
            end
            step();
        end
        rst_i = 1'b1;
        set_idle();
    endtask

`ifdef HAZ_SCHED_PERF_EN
    task automatic test_perf();
        do_reset();
        #1;
        checks++;
        if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: got stall=%0d flush=%0d expected 0/0", stall_cnt_o, flush_cnt_o);
        end
        ex_ctrl_i = `Ctrl_LW; ex_rd_i = 5'd7; id_rs2_i = 5'd7; id_use_rs2_i = 1'b1;
        step();
        set_idle();
        step();
        mem_ctrl_i = `Ctrl_LW;
        for (int i = 0; i < 3; i++) step();
        dmem_ready_i = 1'b1;
        step();
        set_idle();
        id_branch_taken_i = 1'b1;
        step();
        step();
        set_idle();
        step();
        #1;
        checks++;
        if (stall_cnt_o !== 32'd4 || flush_cnt_o !== 32'd2) begin
            errors++;
            $display("FAIL perf_counts: got stall=%0d flush=%0d expected 4/2", stall_cnt_o, flush_cnt_o);
        end
    endtask
`endif

    initial begin
        rst_i = 1'b0;
        set_idle();
        @(negedge clk_i);
        test_reset();
        test_load_use();
        test_zero_rd();
        test_mem_wait();
        test_ready_last_cycle();
        test_branch_during_stall();
        test_timeout();
        test_random();
`ifdef HAZ_SCHED_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
